pipelined_shift_unit: RTL and testbench

- Parametrised, pipelined multi-mode barrel shifter for the processor ALU path; successor to the fixed 32-bit, single-mode left-shift stage chain.
- Supports logical left, logical right, arithmetic right and rotate left over WIDTH bits.
- Shift stages are grouped and registered, with a valid/ready handshake on both sides.
- A tag field is carried with each operation so the writeback logic can match results to their destination register.

---
 rtl/shift_pkg.sv | 16 +
 rtl/shift_stage_mode.sv | 28 ++
 rtl/pipelined_shift_unit.sv | 128 ++++++++++++
 tb/tb_pipelined_shift_unit.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for the pipelined shift unit: op encodings and latency helper.
package shift_pkg;

    typedef enum logic [1:0] {
        SHIFT_SLL = 2'b00,
        SHIFT_SRL = 2'b01,
        SHIFT_SRA = 2'b10,
        SHIFT_ROL = 2'b11
    } shift_op_e;

    // Number of register stages: one register per group of pipe_every shift stages.
    function automatic int calc_latency(input int shamt_w, input int pipe_every);
        return (shamt_w + pipe_every - 1) / pipe_every;
    endfunction

endpackage

// File: rtl/shift_stage_mode.sv
// One combinational shift stage: shifts by DIST when enabled, using the fill rule of op.
module shift_stage_mode
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIST  = 1
) (
    input  logic             en,
    input  logic [1:0]       op,
    input  logic             sign,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Conditional shift; sign is the original operand MSB carried down the pipe.
    always_comb begin
        q = d;
        if (en) begin
            case (shift_op_e'(op))
                SHIFT_SLL: q = {d[WIDTH-1-DIST:0], {DIST{1'b0}}};
                SHIFT_SRL: q = {{DIST{1'b0}}, d[WIDTH-1:DIST]};
                SHIFT_SRA: q = {{DIST{sign}}, d[WIDTH-1:DIST]};
                SHIFT_ROL: q = {d[WIDTH-1-DIST:0], d[WIDTH-1:WIDTH-DIST]};
            endcase
        end
    end

endmodule

// File: rtl/pipelined_shift_unit.sv
// Pipelined multi-mode barrel shifter with valid/ready on both sides and a sideband tag.
// Stages are grouped PIPE_EVERY at a time, each group followed by a register; the last
// register drives the outputs. Data registers load only on valid entries so out_data
// holds the last presented result across bubbles.
module pipelined_shift_unit
    import shift_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int SHAMT_W    = 5,
    parameter int PIPE_EVERY = 2,
    parameter int TAG_W      = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [1:0]         in_op,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [TAG_W-1:0]   out_tag
);

    localparam int NGRP = calc_latency(SHAMT_W, PIPE_EVERY);

    logic               r_valid [NGRP];
    logic [WIDTH-1:0]   r_data  [NGRP];
    logic [SHAMT_W-1:0] r_shamt [NGRP];
    logic [1:0]         r_op    [NGRP];
    logic               r_sign  [NGRP];
    logic [TAG_W-1:0]   r_tag   [NGRP];

    logic               src_valid [NGRP];
    logic [WIDTH-1:0]   src_data  [NGRP];
    logic [SHAMT_W-1:0] src_shamt [NGRP];
    logic [1:0]         src_op    [NGRP];
    logic               src_sign  [NGRP];
    logic [TAG_W-1:0]   src_tag   [NGRP];
    logic [WIDTH-1:0]   grp_data  [NGRP];

    logic [WIDTH-1:0]   stg_in  [SHAMT_W];
    logic [WIDTH-1:0]   stg_out [SHAMT_W];

    logic stall;
    logic unused_ok;

    assign stall     = r_valid[NGRP-1] && !out_ready;
    assign in_ready  = !stall && !flush;
    assign out_valid = r_valid[NGRP-1];
    assign out_data  = r_data[NGRP-1];
    assign out_tag   = r_tag[NGRP-1];

    // The final register only needs valid/data/tag; its control fields go nowhere.
    assign unused_ok = ^{r_shamt[NGRP-1], r_op[NGRP-1], r_sign[NGRP-1]};

    for (genvar g = 0; g < NGRP; g++) begin : g_grp
        localparam int LAST = (((g + 1) * PIPE_EVERY < SHAMT_W) ? (g + 1) * PIPE_EVERY : SHAMT_W) - 1;
        if (g == 0) begin : g_head
            assign src_valid[g] = in_valid && in_ready;
            assign src_data[g]  = in_data;
            assign src_shamt[g] = in_shamt;
            assign src_op[g]    = in_op;
            assign src_sign[g]  = in_data[WIDTH-1];
            assign src_tag[g]   = in_tag;
        end else begin : g_body
            assign src_valid[g] = r_valid[g-1];
            assign src_data[g]  = r_data[g-1];
            assign src_shamt[g] = r_shamt[g-1];
            assign src_op[g]    = r_op[g-1];
            assign src_sign[g]  = r_sign[g-1];
            assign src_tag[g]   = r_tag[g-1];
        end
        assign grp_data[g] = stg_out[LAST];
    end

    for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
        localparam int G = k / PIPE_EVERY;
        if (k % PIPE_EVERY == 0) begin : g_first
            assign stg_in[k] = src_data[G];
        end else begin : g_chain
            assign stg_in[k] = stg_out[k-1];
        end
        shift_stage_mode #(
            .WIDTH(WIDTH),
            .DIST (1 << k)
        ) u_stage (
            .en  (src_shamt[G][k]),
            .op  (src_op[G]),
            .sign(src_sign[G]),
            .d   (stg_in[k]),
            .q   (stg_out[k])
        );
    end

    // Pipeline registers: flush clears valids, stall freezes everything, else advance.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int g = 0; g < NGRP; g++) begin
                r_valid[g] <= 1'b0;
                r_data[g]  <= '0;
                r_shamt[g] <= '0;
                r_op[g]    <= '0;
                r_sign[g]  <= 1'b0;
                r_tag[g]   <= '0;
            end
        end else if (flush) begin
            for (int g = 0; g < NGRP; g++) begin
                r_valid[g] <= 1'b0;
            end
        end else if (!stall) begin
            for (int g = 0; g < NGRP; g++) begin
                r_valid[g] <= src_valid[g];
                if (src_valid[g]) begin
                    r_data[g]  <= grp_data[g];
                    r_shamt[g] <= src_shamt[g];
                    r_op[g]    <= src_op[g];
                    r_sign[g]  <= src_sign[g];
                    r_tag[g]   <= src_tag[g];
                end
            end
        end
    end

endmodule

// File: tb/tb_pipelined_shift_unit.sv
// Directed bench for pipelined_shift_unit at default parameters (LATENCY = 3).
module tb_pipelined_shift_unit;
    import shift_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [4:0]  in_shamt;
    logic [1:0]  in_op;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_tag;

    int n_asserts = 0;
    int n_fail    = 0;

    pipelined_shift_unit dut (
        .clock    (clock),
        .reset    (reset),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_shamt (in_shamt),
        .in_op    (in_op),
        .in_tag   (in_tag),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_tag  (out_tag)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] op, input logic [31:0] a, input logic [4:0] sh, input logic [4:0] tag);
        in_valid = 1'b1;
        in_op    = op;
        in_data  = a;
        in_shamt = sh;
        in_tag   = tag;
    endtask

    // Issue one op, expect it exactly LATENCY cycles later for one cycle, data held after.
    task automatic run_one(input string name, input logic [1:0] op, input logic [31:0] a,
                           input logic [4:0] sh, input logic [4:0] tag, input logic [31:0] exp);
        @(negedge clock);
        drive(op, a, sh, tag);
        @(negedge clock);
        in_valid = 1'b0;
        #1 chk({name, " early"}, out_valid, 1'b0);
        @(negedge clock);
        #1 chk({name, " early2"}, out_valid, 1'b0);
        @(negedge clock);
        #1;
        chk({name, " valid"}, out_valid, 1'b1);
        chk({name, " data"}, out_data, exp);
        chk({name, " tag"}, out_tag, tag);
        @(negedge clock);
        #1;
        chk({name, " one cycle"}, out_valid, 1'b0);
        chk({name, " hold"}, out_data, exp);
    endtask

    initial begin
        int next_tag, exp_tag, hold;
        bit seen;

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_data = '0; in_shamt = '0; in_op = '0; in_tag = '0;
        #12;
        chk("reset out_valid", out_valid, 1'b0);
        chk("reset out_data", out_data, 32'h0);
        chk("reset out_tag", out_tag, 5'd0);
        chk("reset in_ready", in_ready, 1'b1);
        @(negedge clock);
        reset = 1'b0;

        run_one("sll basic", SHIFT_SLL, 32'h0000_00F1, 5'd4, 5'd7, 32'h0000_0F10);

        // Back-to-back SRL, SRA, ROL of the same operand.
        @(negedge clock); drive(SHIFT_SRL, 32'h8000_0010, 5'd4, 5'd1);
        @(negedge clock); drive(SHIFT_SRA, 32'h8000_0010, 5'd4, 5'd2);
        @(negedge clock); drive(SHIFT_ROL, 32'h8000_0010, 5'd4, 5'd3);
        @(negedge clock); in_valid = 1'b0;
        #1; chk("b2b srl valid", out_valid, 1'b1); chk("b2b srl data", out_data, 32'h0800_0001); chk("b2b srl tag", out_tag, 5'd1);
        @(negedge clock);
        #1; chk("b2b sra valid", out_valid, 1'b1); chk("b2b sra data", out_data, 32'hF800_0001); chk("b2b sra tag", out_tag, 5'd2);
        @(negedge clock);
        #1; chk("b2b rol valid", out_valid, 1'b1); chk("b2b rol data", out_data, 32'h0000_0108); chk("b2b rol tag", out_tag, 5'd3);
        @(negedge clock);
        #1; chk("b2b drained", out_valid, 1'b0);

        // Edge shift amounts.
        run_one("sll 31", SHIFT_SLL, 32'h0000_0001, 5'd31, 5'd10, 32'h8000_0000);
        run_one("sra 31", SHIFT_SRA, 32'h8000_0000, 5'd31, 5'd11, 32'hFFFF_FFFF);
        run_one("srl 31", SHIFT_SRL, 32'h8000_0000, 5'd31, 5'd12, 32'h0000_0001);
        run_one("rol 4", SHIFT_ROL, 32'hF000_000F, 5'd4, 5'd13, 32'h0000_00FF);
        run_one("sra pos", SHIFT_SRA, 32'h4000_0000, 5'd3, 5'd14, 32'h0800_0000);
        run_one("sll 0", SHIFT_SLL, 32'h8765_4321, 5'd0, 5'd15, 32'h8765_4321);
        run_one("srl 0", SHIFT_SRL, 32'h8765_4321, 5'd0, 5'd16, 32'h8765_4321);
        run_one("sra 0", SHIFT_SRA, 32'h8765_4321, 5'd0, 5'd17, 32'h8765_4321);
        run_one("rol 0", SHIFT_ROL, 32'h8765_4321, 5'd0, 5'd18, 32'h8765_4321);

        // Backpressure: 6 ops, consumer stalls 4 cycles once the first result shows.
        next_tag = 1; exp_tag = 1; hold = 0; seen = 0;
        for (int cyc = 0; cyc < 40 && exp_tag <= 6; cyc++) begin
            @(negedge clock);
            if (out_valid && !seen) begin
                seen = 1;
                hold = 4;
            end
            out_ready = (hold == 0);
            if (hold > 0) hold--;
            if (next_tag <= 6) drive(SHIFT_SLL, 32'h1, 5'(next_tag), 5'(next_tag));
            else in_valid = 1'b0;
            #1;
            if (!out_ready) begin
                chk("stall in_ready", in_ready, 1'b0);
                chk("stall out_valid", out_valid, 1'b1);
                chk("stall data stable", out_data, 32'h2);
                chk("stall tag stable", out_tag, 5'd1);
            end
            if (out_valid && out_ready) begin
                chk("bp tag order", out_tag, 5'(exp_tag));
                chk("bp data", out_data, 32'(1) << exp_tag);
                exp_tag++;
            end
            if (in_valid && in_ready) next_tag++;
        end
        chk("bp all results within budget", 32'(exp_tag), 32'd7);
        out_ready = 1'b1;
        in_valid  = 1'b0;
        repeat (3) begin
            @(negedge clock);
            #1 chk("bp no extra result", out_valid, 1'b0);
        end

        // Flush with three ops in the pipe; the op presented during flush is dropped.
        @(negedge clock); drive(SHIFT_SLL, 32'h1, 5'd1, 5'd21);
        @(negedge clock); drive(SHIFT_SLL, 32'h1, 5'd2, 5'd22);
        @(negedge clock); drive(SHIFT_SLL, 32'h1, 5'd3, 5'd23);
        @(negedge clock);
        flush = 1'b1;
        drive(SHIFT_SLL, 32'h1, 5'd4, 5'd31);
        #1 chk("flush in_ready", in_ready, 1'b0);
        @(negedge clock);
        flush = 1'b0;
        drive(SHIFT_SLL, 32'h3, 5'd1, 5'd9);
        #1 chk("flush empty 1", out_valid, 1'b0);
        @(negedge clock);
        in_valid = 1'b0;
        #1 chk("flush empty 2", out_valid, 1'b0);
        @(negedge clock);
        #1 chk("flush empty 3", out_valid, 1'b0);
        @(negedge clock);
        #1;
        chk("post flush valid", out_valid, 1'b1);
        chk("post flush data", out_data, 32'h6);
        chk("post flush tag", out_tag, 5'd9);

        // Asynchronous reset with work in flight.
        @(negedge clock); drive(SHIFT_ROL, 32'h1234_5678, 5'd8, 5'd25);
        @(negedge clock); drive(SHIFT_SRL, 32'hFFFF_0000, 5'd8, 5'd26);
        @(negedge clock); drive(SHIFT_SRA, 32'hFFFF_0000, 5'd8, 5'd27);
        @(negedge clock);
        in_valid = 1'b0;
        #1 chk("pre reset valid", out_valid, 1'b1);
        reset = 1'b1;
        #1;
        chk("async reset out_valid", out_valid, 1'b0);
        chk("async reset out_data", out_data, 32'h0);
        chk("async reset out_tag", out_tag, 5'd0);
        @(negedge clock);
        reset = 1'b0;
        #1 chk("after reset in_ready", in_ready, 1'b1);
        repeat (5) begin
            @(negedge clock);
            #1 chk("no stale result", out_valid, 1'b0);
        end

        run_one("after reset op", SHIFT_SRL, 32'h0000_0F00, 5'd8, 5'd5, 32'h0000_000F);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
